// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUop/funct, executes single-cycle ops with a registered result and runs
// iterative signed/unsigned multiply and divide into HI/LO behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_o,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       alu_ctrl,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [3:0] CtrlAnd  = 4'b0000;
    localparam logic [3:0] CtrlOr   = 4'b0001;
    localparam logic [3:0] CtrlAdd  = 4'b0010;
    localparam logic [3:0] CtrlSub  = 4'b0110;
    localparam logic [3:0] CtrlSlt  = 4'b0111;
    localparam logic [3:0] CtrlMult = 4'b1000;
    localparam logic [3:0] CtrlMulu = 4'b1001;
    localparam logic [3:0] CtrlDiv  = 4'b1010;
    localparam logic [3:0] CtrlDivu = 4'b1011;
    localparam logic [3:0] CtrlMfhi = 4'b1100;
    localparam logic [3:0] CtrlMflo = 4'b1101;
    localparam logic [3:0] CtrlNor  = 4'b1110;
    localparam logic [3:0] CtrlIll  = 4'b1111;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q, div0_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 valid_q, valid_d;
    logic [3:0]           ctrl_q, ctrl_d;
    logic                 ill_q, ill_d;

    logic [3:0]           dec_ctrl;
    logic [WIDTH-1:0]     sc_res;
    logic                 op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shl;
    logic                 div_ge;
    logic [WIDTH:0]       div_rem;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Full-funct encodings take priority over the low-nibble R-type encodings.
    always_comb begin
        dec_ctrl = CtrlIll;
        if (aluop == 2'b00) begin
            dec_ctrl = CtrlAdd;
        end else if (aluop[0]) begin
            dec_ctrl = CtrlSub;
        end else begin
            case (funct)
                6'b100111: dec_ctrl = CtrlNor;
                6'b011000: dec_ctrl = MULDIV_EN ? CtrlMult : CtrlIll;
                6'b011001: dec_ctrl = MULDIV_EN ? CtrlMulu : CtrlIll;
                6'b011010: dec_ctrl = MULDIV_EN ? CtrlDiv  : CtrlIll;
                6'b011011: dec_ctrl = MULDIV_EN ? CtrlDivu : CtrlIll;
                6'b010000: dec_ctrl = MULDIV_EN ? CtrlMfhi : CtrlIll;
                6'b010010: dec_ctrl = MULDIV_EN ? CtrlMflo : CtrlIll;
                default: begin
                    case (funct[3:0])
                        4'b0000: dec_ctrl = CtrlAdd;
                        4'b0010: dec_ctrl = CtrlSub;
                        4'b0100: dec_ctrl = CtrlAnd;
                        4'b0101: dec_ctrl = CtrlOr;
                        4'b1010: dec_ctrl = CtrlSlt;
                        default: dec_ctrl = CtrlIll;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        sc_res = '0;
        case (dec_ctrl)
            CtrlAdd:  sc_res = a + b;
            CtrlSub:  sc_res = a - b;
            CtrlAnd:  sc_res = a & b;
            CtrlOr:   sc_res = a | b;
            CtrlNor:  sc_res = ~(a | b);
            CtrlSlt:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CtrlMfhi: sc_res = hi_q;
            CtrlMflo: sc_res = lo_q;
            default:  sc_res = '0;
        endcase
    end

    // Iterations run on magnitudes; signs are re-applied in the FIX state.
    always_comb begin
        op_signed = ~dec_ctrl[0];
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        div_shl   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shl >= {1'b0, opnd_q};
        div_rem   = div_ge ? (div_shl - {1'b0, opnd_q}) : div_shl;

        prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = div0_q ? '1 :
                    (neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
        rem_fix   = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        zero_d    = zero_q;
        valid_d   = 1'b0;
        ctrl_d    = ctrl_q;
        ill_d     = ill_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    ctrl_d    = dec_ctrl;
                    ill_d     = (dec_ctrl == CtrlIll);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = CntW'(WIDTH);
                    if (dec_ctrl == CtrlMult || dec_ctrl == CtrlMulu) begin
                        state_d  = StMul;
                        acc_d    = {{WIDTH{1'b0}}, b_mag};
                        opnd_d   = a_mag;
                        is_div_d = 1'b0;
                        div0_d   = 1'b0;
                    end else if (dec_ctrl == CtrlDiv || dec_ctrl == CtrlDivu) begin
                        state_d  = StDiv;
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        opnd_d   = b_mag;
                        is_div_d = 1'b1;
                        div0_d   = (b == '0);
                    end else begin
                        valid_d  = 1'b1;
                        result_d = sc_res;
                        zero_d   = (sc_res == '0);
                    end
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StFix;
            end
            StDiv: begin
                acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                result_d = lo_d;
                zero_d   = (lo_d == '0);
                valid_d  = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            valid_q   <= 1'b0;
            ctrl_q    <= 4'b0000;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            ill_q     <= ill_d;
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign valid_o  = valid_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign alu_ctrl = ctrl_q;
    assign illegal  = ill_q;
    assign hi       = MULDIV_EN ? hi_q : '0;
    assign lo       = MULDIV_EN ? lo_q : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit, checked against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic         ready_o;
    logic [1:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic         valid_o;
    logic [W-1:0] result;
    logic         zero;
    logic [3:0]   alu_ctrl;
    logic         illegal;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .aluop    (aluop),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .valid_o  (valid_o),
        .result   (result),
        .zero     (zero),
        .alu_ctrl (alu_ctrl),
        .illegal  (illegal),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        ill;
        logic        md;
        logic [31:0] nhi;
        logic [31:0] nlo;
    } exp_t;

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    logic [31:0]  m_hi = '0;
    logic [31:0]  m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like the hardware.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] h, input logic [31:0] l);
        exp_t            e;
        longint          sx, sy, p, q, r;
        longint unsigned up;
        sx = $signed(x);
        sy = $signed(y);
        e = '0;
        e.nhi = h;
        e.nlo = l;
        if (op == 2'b00) begin
            e.ctrl = 4'b0010; e.res = x + y;
        end else if (op[0]) begin
            e.ctrl = 4'b0110; e.res = x - y;
        end else if (f == 6'b100111) begin
            e.ctrl = 4'b1110; e.res = ~(x | y);
        end else if (f == 6'b011000) begin
            e.ctrl = 4'b1000; e.md = 1'b1;
            p = sx * sy;
            {e.nhi, e.nlo} = p;
        end else if (f == 6'b011001) begin
            e.ctrl = 4'b1001; e.md = 1'b1;
            up = {32'b0, x} * {32'b0, y};
            {e.nhi, e.nlo} = up;
        end else if (f == 6'b011010) begin
            e.ctrl = 4'b1010; e.md = 1'b1;
            if (y == 0) begin
                e.nhi = x; e.nlo = '1;
            end else begin
                q = sx / sy; r = sx % sy;
                e.nlo = 32'(q); e.nhi = 32'(r);
            end
        end else if (f == 6'b011011) begin
            e.ctrl = 4'b1011; e.md = 1'b1;
            if (y == 0) begin
                e.nhi = x; e.nlo = '1;
            end else begin
                e.nlo = x / y; e.nhi = x % y;
            end
        end else if (f == 6'b010000) begin
            e.ctrl = 4'b1100; e.res = h;
        end else if (f == 6'b010010) begin
            e.ctrl = 4'b1101; e.res = l;
        end else begin
            case (f[3:0])
                4'b0000: begin e.ctrl = 4'b0010; e.res = x + y; end
                4'b0010: begin e.ctrl = 4'b0110; e.res = x - y; end
                4'b0100: begin e.ctrl = 4'b0000; e.res = x & y; end
                4'b0101: begin e.ctrl = 4'b0001; e.res = x | y; end
                4'b1010: begin e.ctrl = 4'b0111; e.res = (sx < sy) ? 32'd1 : 32'd0; end
                default: begin e.ctrl = 4'b1111; e.res = '0; e.ill = 1'b1; end
            endcase
        end
        if (e.md) e.res = e.nlo;
        return e;
    endfunction

    // Single-cycle ops leave valid_i high so consecutive calls accept back to back.
    task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   k, busy;
        e = model(op, f, x, y, m_hi, m_lo);
        @(negedge clk);
        aluop = op; funct = f; a = x; b = y; valid_i = 1'b1;
        @(posedge clk); #1;
        if (e.md) begin
            k = 1;
            busy = 0;
            while (!valid_o && k < 3 * W) begin
                if (!ready_o) busy++;
                @(negedge clk);
                valid_i = 1'b0;
                @(posedge clk); #1;
                k++;
            end
            check("md_latency", k, W + 2);
            check("md_busy_cycles", busy, W + 1);
        end
        check("valid_o", valid_o, 1'b1);
        check("ready_o", ready_o, 1'b1);
        check("result", result, e.res);
        check("zero", zero, (e.res == 0));
        check("alu_ctrl", alu_ctrl, e.ctrl);
        check("illegal", illegal, e.ill);
        check("hi", hi, e.nhi);
        check("lo", lo, e.nlo);
        m_hi = e.nhi;
        m_lo = e.nlo;
    endtask

    task automatic idle();
        @(negedge clk);
        valid_i = 1'b0;
        aluop = 2'($urandom);
        funct = 6'($urandom);
        @(posedge clk); #1;
        check("idle_valid_o", valid_o, 1'b0);
        check("idle_ready_o", ready_o, 1'b1);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [5:0]  fl [13];
        logic [1:0]  op;
        logic [5:0]  f;
        int          seen;

        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111,
               6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010,
               6'b000111};

        rst_n = 1'b0; valid_i = 1'b0; aluop = '0; funct = '0; a = '0; b = '0;
        #12;
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1'b0);
        check("rst_alu_ctrl", alu_ctrl, 4'b0000);
        check("rst_illegal", illegal, 1'b0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready_o", ready_o, 1'b1);
        check("post_rst_valid_o", valid_o, 1'b0);

        run_op(2'b10, 6'b100010, 32'd5, 32'd7);
        run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
        run_op(2'b01, 6'b000000, 32'd9, 32'd9);
        idle();

        run_op(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7);
        run_op(2'b10, 6'b010010, 32'd0, 32'd0);
        run_op(2'b10, 6'b010000, 32'd0, 32'd0);
        idle();

        run_op(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 6'b011011, 32'd9, 32'd0);
        run_op(2'b10, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 6'b011010, 32'hFFFF_FFF9, 32'd0);
        run_op(2'b10, 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle();

        // Abort a MULTU ten cycles after accept.
        @(negedge clk);
        aluop = 2'b10; funct = 6'b011001; a = 32'hFFFF_FFFF; b = 32'd2; valid_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready_o", ready_o, 1'b1);
        check("abort_valid_o", valid_o, 1'b0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_alu_ctrl", alu_ctrl, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (3 * W) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        check("abort_no_valid_o", seen, 0);
        m_hi = '0;
        m_lo = '0;

        run_op(2'b10, 6'b000111, 32'd3, 32'd4);
        run_op(2'b10, 6'b100000, 32'hFFFF_FFF0, 32'h20);
        run_op(2'b10, 6'b100101, 32'h0F0F_0000, 32'h0000_00F0);
        run_op(2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0);
        idle();

        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 12)];
            run_op(op, f, pick_val(), pick_val());
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decoder.
- Decodes ALUop/funct into the 4-bit ALU control code and executes the operation. Single-cycle ops have a registered result.
- Adds iterative multiply/divide (MULT, MULTU, DIV, DIVU) with HI/LO registers and MFHI/MFLO reads, behind a valid/ready handshake.
- Sits in the EX stage between the main decoder and the writeback mux; ready_o drives the pipeline stall.

Parameters:
- WIDTH, 32, datapath width in bits (>=8).
- MULDIV_EN, 1, 1 = multiply/divide/MFHI/MFLO implemented; 0 = those functs flagged illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- valid_i  input  1  operation request.
- ready_o  output  1  unit can accept (high only in IDLE).
- aluop  input  2  main-decoder ALU op.
- funct  input  6  R-type funct field.
- a  input  WIDTH  operand rs.
- b  input  WIDTH  operand rt.
- valid_o  output  1  one-cycle pulse: result/flags valid.
- result  output  WIDTH  operation result (LO for mult/div).
- zero  output  1  result == 0.
- alu_ctrl  output  4  registered control code of the accepted op.
- illegal  output  1  accepted op was not decodable (valid with valid_o).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state IDLE; ready_o=1; valid_o=0; result=0; zero=0; alu_ctrl=0000; illegal=0; hi=0; lo=0. Reset mid-operation aborts it: no valid_o, HI/LO cleared.
- Accept: valid_i && ready_o on a rising edge. No output backpressure; valid_o is never stalled.
- Decode priority: full 6-bit funct matches first, then low-nibble matches.
  - aluop 00 -> add (0010).
  - aluop ?1 -> sub (0110).
  - aluop 10, full funct matches:
    - 100111 nor (1110).
    - 011000 MULT (1000).
    - 011001 MULTU (1001).
    - 011010 DIV (1010).
    - 011011 DIVU (1011).
    - 010000 MFHI (1100).
    - 010010 MFLO (1101).
  - aluop 10, funct[3:0] matches:
    - 0000 add (0010).
    - 0010 sub (0110).
    - 0100 and (0000).
    - 0101 or (0001).
    - 1010 slt (0111).
  - Anything else -> illegal: alu_ctrl 1111, result 0, illegal=1.
- Arithmetic:
  - All results modulo 2^WIDTH.
  - slt is signed: result 1 if $signed(a)<$signed(b), else 0.
  - nor = ~(a|b).
- Single-cycle ops (including MFHI/MFLO and illegal):
  - Result registered; valid_o pulses on the cycle after accept (latency 1).
  - Unit stays in IDLE, so back-to-back accepts every cycle are allowed.
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL (mult accepted) or DIV (div accepted); operand magnitudes, sign flags and a counter are loaded.
  - MUL: one shift-add step per cycle for WIDTH cycles; 2*WIDTH-bit product on magnitudes (unsigned for MULTU).
  - DIV: one restoring step per cycle for WIDTH cycles on magnitudes (unsigned for DIVU).
  - When the counter reaches 0 -> FIX.
  - FIX (1 cycle) applies sign correction:
    - Product is negated if the operand signs differ.
    - Quotient sign = sign(a) xor sign(b).
    - Remainder takes the sign of a (truncating division).
    - Writes hi/lo, then -> IDLE. valid_o pulses the cycle after FIX with result=lo.
- Mult/div latency: accept to valid_o = WIDTH+2 cycles. ready_o=0 from the cycle after accept until the valid_o cycle, inclusive of FIX.
- Divide by zero: runs full latency; final hi=a, lo=all ones. No trap.
- Most-negative operand: signed DIV of 0x80..0 by -1 gives lo=0x80..0, hi=0.
- MFHI/MFLO read the current hi/lo; they cannot be accepted while busy because ready_o=0.
- valid_i while ready_o=0 is ignored; the requester holds it.
- zero is computed from the registered result. It updates only with valid_o and otherwise holds.
- MULDIV_EN=0: no MUL/DIV/FIX states. The six mult/div/mf functs decode as illegal. hi/lo are tied to 0.

Test Plan:
- Reset with rst_n=0 -> all outputs 0, ready_o=1. Release rst_n -> ready_o stays 1, valid_o=0.
- aluop=10, funct=100010, a=5, b=7 -> next cycle valid_o=1, result=0xFFFFFFFE, alu_ctrl=0110, zero=0. Then funct=101010, a=0xFFFFFFFF, b=1 -> result=1, alu_ctrl=0111. Then aluop=01, a=b=9 -> result=0, zero=1.
- MULT a=0xFFFFFFFD (-3), b=7 -> ready_o low for 33 cycles, valid_o at accept+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MFLO -> result=0xFFFFFFEB; MFHI -> result=0xFFFFFFFF.
- Division cases:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=9, b=0 -> lo=0xFFFFFFFF, hi=9.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU a=0xFFFFFFFF, b=2; pulse rst_n low at accept+10 -> no valid_o ever, hi=lo=0, ready_o=1 immediately.
- aluop=10, funct=000111 -> valid_o=1, illegal=1, alu_ctrl=1111, result=0. Back-to-back accepts of add/or/and on consecutive cycles -> three consecutive valid_o pulses with correct results.
